cache_line_fill: RTL and testbench
==================================

Name: cache_line_fill

Overview:
- Refill engine upstream of the cache lane storage and the word-select stage that reads it.
- On a miss, it fetches one full cache line from memory over an Avalon-MM read master, one 32-bit beat at a time.
- It assembles the beats into a line register, then presents the finished line with a one-cycle write strobe.
- The strobe tells the cache to write the line into the set given by pos.

Parameters:
- log_of_number_of_sets, 2, width of the set index (pos).
- bits_for_offset, 3, log2 of line size in bytes; must be >= 2.
- single_lane_size, 8*(2**bits_for_offset), line width in bits (derived; do not override).
- beats, 2**(bits_for_offset-2), number of 32-bit words per line (derived).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- fill_req  in  1  start a refill; sampled only while busy=0.
- fill_addr  in  32  byte address of the missing word.
- fill_pos  in  log_of_number_of_sets  destination set index.
- busy  out  1  refill in progress.
- avm_address  out  32  word-aligned read address.
- avm_read  out  1  Avalon read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data valid.
- line_data  out  single_lane_size  assembled line; word k occupies bits [32k+31:32k].
- line_addr  out  32  line base address (offset bits zero).
- line_pos  out  log_of_number_of_sets  registered fill_pos.
- line_valid  out  1  one-cycle write strobe; line_data, line_addr and line_pos are stable while it is high.
- word_valid  out  1  early critical-word strobe (optional feature).
- word_data  out  32  early critical word (optional feature).

Behaviour:
- Reset (asynchronous): every output goes to 0 and the FSM goes to IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - busy=0.
  - fill_req=1 at a clock edge captures:
    - line_addr = {fill_addr[31:bits_for_offset], zeros};
    - line_pos;
    - start word s;
  - beat counter cnt is cleared to 0 and the FSM goes to REQ.
- REQ:
  - avm_read=1 and avm_address = line_addr + 4*((s+cnt) mod beats).
  - Address and read are held stable while avm_waitrequest=1.
  - avm_waitrequest=0 at the edge → WAIT.
- WAIT:
  - avm_read=0.
  - On avm_readdatavalid=1, avm_readdata is stored into word (s+cnt) mod beats of line_data.
  - If cnt == beats-1 → DONE; otherwise cnt++ → REQ.
- DONE: line_valid=1 for exactly one cycle, then → IDLE.
- busy=1 in REQ, WAIT and DONE.
- Only one outstanding read at a time; no bursts.
- Latency with zero wait states and readdatavalid one cycle after the accepted read: line_valid is high in the cycle after clock edge 2*beats, counting the accept edge as edge 0.
- fill_req while busy=1 is ignored. It is not queued; the requester must hold it or re-issue it.
- avm_readdatavalid in IDLE, REQ or DONE is ignored.
- Word index arithmetic wraps modulo beats; cnt is log2(beats) bits, with a minimum width of 1.
- Reset asserted mid-fill:
  - the fill is aborted immediately and partial data is discarded;
  - line_valid does not pulse;
  - readdatavalid for the abandoned read, arriving after reset is released, is ignored because the FSM is in IDLE.
- line_data keeps its last value until the next fill overwrites it word by word.

Optional Feature:
- Macro: CACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - s = fill_addr[bits_for_offset-1:2], so the fetch starts at the missing word and wraps within the line.
  - When the first beat is captured, word_valid pulses for one cycle (the cycle after the capture edge) with word_data = that beat, so the core can restart early.
- Not defined:
  - s = 0, so words are fetched in ascending order.
  - word_valid and word_data are tied to 0.
- line_data content is identical in both builds.

Decomposition:
- Shared package:
  - FSM state encoding (2-bit localparams);
  - WORD_BYTES=4;
  - the derived-width functions for single_lane_size and beats, shared with the lane-select and cache-control blocks.
- No sub-module needed. One small helper, avm_word_addr (line base + wrapped word index), can be a function in the package.

Test Plan (defaults: 8-byte line, beats=2):
- Plain fill:
  - stimulus: fill_addr=0x0000_1004, fill_pos=2; memory returns 0xAAAA0000 at 0x1000 and 0xBBBB1111 at 0x1004;
  - response: avm_address sequence 0x1000 then 0x1004; line_data=0xBBBB1111_AAAA0000, line_addr=0x1000, line_pos=2; line_valid high for one cycle after edge 4.
- Wait states:
  - stimulus: avm_waitrequest held 1 for 3 cycles on the first read;
  - response: avm_read and avm_address=0x1000 stable throughout; line_valid delayed by exactly 3 cycles.
- Busy rejection:
  - stimulus: second fill_req (addr 0x2000) during WAIT;
  - response: ignored; line_addr stays 0x1000; no fetch at 0x2000 until it is re-issued after busy=0.
- Reset mid-fill:
  - stimulus: reset during WAIT of beat 0, then a stray readdatavalid after release;
  - response: all outputs 0, FSM in IDLE, no line_valid, line_data unchanged by the stray beat.
- Critical word first (macro defined):
  - stimulus: fill_addr=0x1004;
  - response: address order 0x1004 then 0x1000; word_valid pulses once with word_data=0xBBBB1111; final line_data is the same as in the plain-fill case.
- Back-to-back fills:
  - stimulus: fill_req held high across DONE;
  - response: new fill accepted at the first IDLE edge, with line_valid pulses separated by at least 2*beats+2 cycles.

Source files
------------

// File: rtl/cache_line_fill_pkg.sv
// Shared definitions for the cache refill path.
// Contents: the refill FSM state encoding, the Avalon word size, the derived
// line geometry functions (also used by the lane-select and cache-control
// blocks), and the helper that forms a word address inside a line.
package cache_line_fill_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fill_state_t;

  // Line width in bits for a line of 2**offset_bits bytes.
  function automatic int lane_bits(input int offset_bits);
    return 8 * (2 ** offset_bits);
  endfunction

  // Number of 32-bit words in a line of 2**offset_bits bytes.
  function automatic int line_beats(input int offset_bits);
    return 2 ** (offset_bits - 2);
  endfunction

  // Width of a word index / beat counter; never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte address of word idx inside the line starting at base.
  function automatic logic [31:0] avm_word_addr(input logic [31:0] base,
                                                input logic [31:0] idx);
    return base + idx * 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/cache_line_fill_if.sv
// Avalon-MM read-only bus between the refill engine and memory.
// Signals: avm_address (word-aligned byte address), avm_read (request),
// avm_waitrequest (slave stall), avm_readdata, avm_readdatavalid.
// Modports: master (refill engine side), slave (memory side).
interface cache_line_fill_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/cache_line_fill.sv
// Cache line refill engine.
// On fill_req (while idle) it fetches one cache line over an Avalon-MM read
// master, one 32-bit beat at a time with a single outstanding read, assembles
// the beats into line_data and presents the finished line with a one-cycle
// line_valid strobe together with line_addr (line base) and line_pos (set).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   fill_req/addr/pos     refill request, missing byte address, target set
//   busy                  refill in progress
//   avm                   Avalon-MM read master (cache_line_fill_if.master)
//   line_data/addr/pos    assembled line, base address, set index
//   line_valid            one-cycle write strobe for the assembled line
//   word_valid/word_data  early critical-word strobe and data
// Build option: CACHE_CRITICAL_WORD_FIRST_EN starts the fetch at the missing
// word (wrapping within the line) and pulses word_valid with the first beat.
// Without it words are fetched in ascending order and word_* are tied to 0.
module cache_line_fill
  import cache_line_fill_pkg::*;
#(
  parameter int log_of_number_of_sets = 2,
  parameter int bits_for_offset       = 3,
  parameter int single_lane_size      = lane_bits(bits_for_offset),
  parameter int beats                 = line_beats(bits_for_offset)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fill_req,
  input  logic [31:0]                      fill_addr,
  input  logic [log_of_number_of_sets-1:0] fill_pos,
  output logic                             busy,
  cache_line_fill_if.master                avm,
  output logic [single_lane_size-1:0]      line_data,
  output logic [31:0]                      line_addr,
  output logic [log_of_number_of_sets-1:0] line_pos,
  output logic                             line_valid,
  output logic                             word_valid,
  output logic [31:0]                      word_data
);

  localparam int CW = cnt_bits(beats);

  fill_state_t   state;
  fill_state_t   state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] start_word;
  logic [CW-1:0] start_word_nxt;
  logic [CW-1:0] idx;
  logic          last_beat;
  logic          beat_in;

  // Low address bits only select the start word (or nothing at all).
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, fill_addr[bits_for_offset-1:0]};

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  // Masking with beats-1 keeps this valid down to a single-word line.
  assign start_word_nxt = CW'(fill_addr[31:2] & 30'(beats - 1));
`else
  assign start_word_nxt = '0;
`endif

  // Current word slot, wrapping within the line.
  assign idx       = CW'((32'(start_word) + 32'(cnt)) % 32'(beats));
  assign last_beat = (cnt == CW'(beats - 1));
  assign beat_in   = (state == WAIT) && avm.avm_readdatavalid;

  assign busy            = (state != IDLE);
  assign line_valid      = (state == DONE);
  assign avm.avm_read    = (state == REQ);
  assign avm.avm_address = (state == REQ) ? avm_word_addr(line_addr, 32'(idx)) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (fill_req) state_nxt = REQ;
      REQ:  if (!avm.avm_waitrequest) state_nxt = WAIT;
      WAIT: if (avm.avm_readdatavalid) state_nxt = last_beat ? DONE : REQ;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      start_word <= '0;
      line_addr  <= '0;
      line_pos   <= '0;
      line_data  <= '0;
    end else begin
      if ((state == IDLE) && fill_req) begin
        cnt        <= '0;
        start_word <= start_word_nxt;
        line_addr  <= {fill_addr[31:bits_for_offset], {bits_for_offset{1'b0}}};
        line_pos   <= fill_pos;
      end
      if (beat_in) begin
        line_data[idx*32 +: 32] <= avm.avm_readdata;
        if (!last_beat) cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  // The first beat of a fill is the word the core missed on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= beat_in && (cnt == '0);
      if (beat_in && (cnt == '0)) word_data <= avm.avm_readdata;
    end
  end
`else
  assign word_valid = 1'b0;
  assign word_data  = '0;
`endif

endmodule

// File: tb/tb_cache_line_fill.sv
module tb_cache_line_fill;
  import cache_line_fill_pkg::*;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        fill_req;
  logic [31:0] fill_addr;
  logic [1:0]  fill_pos;
  logic        busy;
  logic [63:0] line_data;
  logic [31:0] line_addr;
  logic [1:0]  line_pos;
  logic        line_valid;
  logic        word_valid;
  logic [31:0] word_data;

  int total = 0;
  int bad   = 0;

  cache_line_fill_if bus ();

  cache_line_fill dut (
    .clk        (clk),
    .reset      (reset),
    .fill_req   (fill_req),
    .fill_addr  (fill_addr),
    .fill_pos   (fill_pos),
    .busy       (busy),
    .avm        (bus),
    .line_data  (line_data),
    .line_addr  (line_addr),
    .line_pos   (line_pos),
    .line_valid (line_valid),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory contents served by the bench.
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'hAAAA_0000;
      32'h0000_1004: return 32'hBBBB_1111;
      32'h0000_2000: return 32'h1111_2222;
      32'h0000_2004: return 32'h3333_4444;
      default:       return 32'h0;
    endcase
  endfunction

  // One complete fill of a two-word line. Ends in the DONE cycle with the
  // line outputs checked. ws0 = wait states on the first read; intrude
  // raises a competing fill_req during the first WAIT; hold leaves fill_req
  // asserted (for next_addr) through DONE.
  task automatic run_fill(input logic [31:0] addr, input logic [1:0] pos,
                          input logic [63:0] exp_line, input int ws0,
                          input bit intrude, input bit hold,
                          input logic [31:0] next_addr);
    logic [31:0] base;
    logic [31:0] a;
    int          s;
    int          w;
    base = {addr[31:3], 3'b000};
    s    = CWF ? int'(addr[2]) : 0;
    fill_req  = 1'b1;
    fill_addr = addr;
    fill_pos  = pos;
    tick();
    fill_req = 1'b0;
    chk("busy_after_accept", busy, 1);
    for (int b = 0; b < 2; b++) begin
      w = (s + b) % 2;
      a = base + 32'(4 * w);
      for (int k = 0; k < ((b == 0) ? ws0 : 0); k++) begin
        bus.avm_waitrequest = 1'b1;
        chk("read_held", bus.avm_read, 1);
        chk("addr_held", bus.avm_address, a);
        tick();
      end
      bus.avm_waitrequest = 1'b0;
      chk("read_req", bus.avm_read, 1);
      chk("read_addr", bus.avm_address, a);
      tick();
      chk("read_low_in_wait", bus.avm_read, 0);
      if (b == 1) chk("word_valid_one_cycle", word_valid, 0);
      if (intrude && b == 0) begin
        fill_req  = 1'b1;
        fill_addr = 32'h0000_2000;
        fill_pos  = 2'd0;
      end
      if (hold && b == 1) begin
        fill_req  = 1'b1;
        fill_addr = next_addr;
        fill_pos  = 2'd3;
      end
      chk("no_line_valid_early", line_valid, 0);
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = mem(a);
      tick();
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = 32'h0;
      if (!(hold && b == 1)) fill_req = 1'b0;
      if (b == 0) begin
        chk("word_valid", word_valid, CWF);
        if (CWF) chk("word_data", word_data, mem(a));
      end
    end
    chk("line_valid", line_valid, 1);
    chk("line_data", line_data, exp_line);
    chk("line_addr", line_addr, base);
    chk("line_pos", line_pos, pos);
    chk("busy_in_done", busy, 1);
  endtask

  initial begin
    reset                 = 1'b1;
    fill_req              = 1'b0;
    fill_addr             = 32'h0;
    fill_pos              = 2'd0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdata      = 32'h0;
    bus.avm_readdatavalid = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_read", bus.avm_read, 0);
    chk("rst_addr", bus.avm_address, 0);
    chk("rst_line_data", line_data, 0);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_word_valid", word_valid, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Plain fill: line_valid in the cycle after edge 4.
    run_fill(32'h0000_1004, 2'd2, 64'hBBBB1111_AAAA0000, 0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("strobe_one_cycle", line_valid, 0);
    chk("idle_after_done", busy, 0);

    // Three wait states on the first read plus a competing request in WAIT.
    run_fill(32'h0000_1000, 2'd1, 64'hBBBB1111_AAAA0000, 3, 1'b1, 1'b0, 32'h0);
    tick();
    chk("busy_clear", busy, 0);
    tick();
    chk("rejected_req_not_fetched", bus.avm_read, 0);
    chk("rejected_req_no_busy", busy, 0);
    chk("line_addr_kept", line_addr, 32'h0000_1000);

    // Re-issued 0x2000 fill, with fill_req held through DONE for 0x1000.
    run_fill(32'h0000_2000, 2'd0, 64'h33334444_11112222, 0, 1'b0, 1'b1, 32'h0000_1000);
    tick();
    chk("b2b_idle_gap_busy", busy, 0);
    chk("b2b_idle_gap_strobe", line_valid, 0);
    run_fill(32'h0000_1000, 2'd3, 64'hBBBB1111_AAAA0000, 0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("b2b_end_idle", busy, 0);

    // Reset during WAIT of beat 0, then a stray readdatavalid.
    fill_req  = 1'b1;
    fill_addr = 32'h0000_2004;
    fill_pos  = 2'd1;
    tick();
    fill_req = 1'b0;
    tick();
    chk("pre_reset_in_wait", bus.avm_read, 0);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_line_data", line_data, 0);
    chk("midrst_line_addr", line_addr, 0);
    chk("midrst_line_pos", line_pos, 0);
    chk("midrst_line_valid", line_valid, 0);
    tick();
    reset = 1'b0;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'hDEAD_BEEF;
    tick();
    bus.avm_readdatavalid = 1'b0;
    chk("stray_line_data", line_data, 0);
    chk("stray_busy", busy, 0);
    chk("stray_word_valid", word_valid, 0);
    tick();
    chk("stray_no_line_valid", line_valid, 0);
    chk("stray_no_read", bus.avm_read, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
